// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse character scheduler.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SYMGAP,
        ST_LETGAP,
        ST_WORDGAP
    } state_t;

    // Morse table entry: len elements (1..5); pat bit 0 is sent first, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } lut_entry_t;

    localparam int unsigned DOT_UNITS        = 1;
    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned SYM_GAP_UNITS    = 1;
    localparam int unsigned LET_GAP_UNITS    = 3;
    localparam int unsigned WORD_EXTRA_UNITS = 4;
    localparam int unsigned MAX_ELEMS        = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII -> Morse lookup (ITU table for A-Z and 0-9, lowercase folded).
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0]  i_char,
    output logic        o_valid,
    output lut_entry_t  o_entry
);

    logic [7:0] w_up;

    // Fold lowercase onto uppercase, then look the character up.
    always_comb begin
        w_up    = i_char;
        o_valid = 1'b1;
        o_entry = '0;
        if (i_char >= 8'h61 && i_char <= 8'h7A) begin
            w_up = i_char - 8'h20;
        end
        case (w_up)
            8'h41: o_entry = '{3'd2, 5'b00010}; // A .-
            8'h42: o_entry = '{3'd4, 5'b00001}; // B -...
            8'h43: o_entry = '{3'd4, 5'b00101}; // C -.-.
            8'h44: o_entry = '{3'd3, 5'b00001}; // D -..
            8'h45: o_entry = '{3'd1, 5'b00000}; // E .
            8'h46: o_entry = '{3'd4, 5'b00100}; // F ..-.
            8'h47: o_entry = '{3'd3, 5'b00011}; // G --.
            8'h48: o_entry = '{3'd4, 5'b00000}; // H ....
            8'h49: o_entry = '{3'd2, 5'b00000}; // I ..
            8'h4A: o_entry = '{3'd4, 5'b01110}; // J .---
            8'h4B: o_entry = '{3'd3, 5'b00101}; // K -.-
            8'h4C: o_entry = '{3'd4, 5'b00010}; // L .-..
            8'h4D: o_entry = '{3'd2, 5'b00011}; // M --
            8'h4E: o_entry = '{3'd2, 5'b00001}; // N -.
            8'h4F: o_entry = '{3'd3, 5'b00111}; // O ---
            8'h50: o_entry = '{3'd4, 5'b00110}; // P .--.
            8'h51: o_entry = '{3'd4, 5'b01011}; // Q --.-
            8'h52: o_entry = '{3'd3, 5'b00010}; // R .-.
            8'h53: o_entry = '{3'd3, 5'b00000}; // S ...
            8'h54: o_entry = '{3'd1, 5'b00001}; // T -
            8'h55: o_entry = '{3'd3, 5'b00100}; // U ..-
            8'h56: o_entry = '{3'd4, 5'b01000}; // V ...-
            8'h57: o_entry = '{3'd3, 5'b00110}; // W .--
            8'h58: o_entry = '{3'd4, 5'b01001}; // X -..-
            8'h59: o_entry = '{3'd4, 5'b01101}; // Y -.--
            8'h5A: o_entry = '{3'd4, 5'b00011}; // Z --..
            8'h30: o_entry = '{3'd5, 5'b11111}; // 0 -----
            8'h31: o_entry = '{3'd5, 5'b11110}; // 1 .----
            8'h32: o_entry = '{3'd5, 5'b11100}; // 2 ..---
            8'h33: o_entry = '{3'd5, 5'b11000}; // 3 ...--
            8'h34: o_entry = '{3'd5, 5'b10000}; // 4 ....-
            8'h35: o_entry = '{3'd5, 5'b00000}; // 5 .....
            8'h36: o_entry = '{3'd5, 5'b00001}; // 6 -....
            8'h37: o_entry = '{3'd5, 5'b00011}; // 7 --...
            8'h38: o_entry = '{3'd5, 5'b00111}; // 8 ---..
            8'h39: o_entry = '{3'd5, 5'b01111}; // 9 ----.
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_char_scheduler.sv
// One-character-at-a-time Morse scheduler: handshake in, timed ONOFF/isDash out.
module morse_char_scheduler
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned CLK_SPEED   = 160
) (
    input  logic       UnitClock,
    input  logic       Reset_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       ONOFF,
    output logic       isDash,
    output logic       busy,
    output logic       char_err
);

    if (UNIT_CYCLES < 1 || CLK_SPEED == 0) begin : g_bad_param
        $error("morse_char_scheduler: UNIT_CYCLES must be >= 1 and CLK_SPEED nonzero");
    end

    localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DOT_LAST  = cnt_t'(DOT_UNITS        * UNIT_CYCLES - 1);
    localparam cnt_t DASH_LAST = cnt_t'(DASH_UNITS       * UNIT_CYCLES - 1);
    localparam cnt_t SYM_LAST  = cnt_t'(SYM_GAP_UNITS    * UNIT_CYCLES - 1);
    localparam cnt_t LET_LAST  = cnt_t'(LET_GAP_UNITS    * UNIT_CYCLES - 1);
    localparam cnt_t WORD_LAST = cnt_t'(WORD_EXTRA_UNITS * UNIT_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    cnt_t       r_cnt,   w_cnt_nxt;
    logic [4:0] r_pat,   w_pat_nxt;
    logic [2:0] r_len,   w_len_nxt;
    logic [2:0] r_idx,   w_idx_nxt;
    logic       r_onoff, r_isdash, r_busy, r_err;
    logic       w_onoff_nxt, w_isdash_nxt, w_busy_nxt, w_err_nxt;

    logic       w_xfer;
    logic       w_lut_valid;
    lut_entry_t w_lut_entry;

    morse_lut u_lut (
        .i_char  (char_in),
        .o_valid (w_lut_valid),
        .o_entry (w_lut_entry)
    );

    assign char_ready = (r_state == ST_IDLE);
    assign w_xfer     = char_valid && char_ready;

    assign ONOFF    = r_onoff;
    assign isDash   = r_isdash;
    assign busy     = r_busy;
    assign char_err = r_err;

    // State, counters and registered outputs.
    always_ff @(posedge UnitClock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pat    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_onoff  <= 1'b0;
            r_isdash <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pat    <= w_pat_nxt;
            r_len    <= w_len_nxt;
            r_idx    <= w_idx_nxt;
            r_onoff  <= w_onoff_nxt;
            r_isdash <= w_isdash_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next state: each timed state counts down from duration-1 and moves on at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_xfer) begin
                    if (w_lut_valid) begin
                        w_state_nxt = ST_MARK;
                        w_pat_nxt   = w_lut_entry.pat;
                        w_len_nxt   = w_lut_entry.len;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = w_lut_entry.pat[0] ? DASH_LAST : DOT_LAST;
                    end else if (char_in == ASCII_SPACE) begin
                        w_state_nxt = ST_WORDGAP;
                        w_cnt_nxt   = WORD_LAST;
                    end
                end
            end
            ST_MARK: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_idx == r_len - 3'd1) begin
                    w_state_nxt = ST_LETGAP;
                    w_cnt_nxt   = LET_LAST;
                end else begin
                    w_state_nxt = ST_SYMGAP;
                    w_cnt_nxt   = SYM_LAST;
                    w_idx_nxt   = r_idx + 3'd1;
                end
            end
            ST_SYMGAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_MARK;
                    w_cnt_nxt   = r_pat[r_idx] ? DASH_LAST : DOT_LAST;
                end
            end
            ST_LETGAP, ST_WORDGAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        w_onoff_nxt  = (w_state_nxt == ST_MARK);
        w_isdash_nxt = (w_state_nxt == ST_MARK) && w_pat_nxt[w_idx_nxt];
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_err_nxt    = w_xfer && !w_lut_valid && (char_in != ASCII_SPACE);
    end

endmodule
